// File: rtl/mac_job_scheduler_pkg.sv
// mac_job_scheduler_pkg
//   Shared types and defaults for the MAC job scheduler.
//   state_e : scheduler FSM states (IDLE, STREAM)
//   res_t   : returned result record (tag, sum, isInf, overflow)
package mac_job_scheduler_pkg;

  localparam int LEN_W_DEF = 16;
  localparam int TAG_W_DEF = 8;
  localparam int DATA_W    = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [DATA_W-1:0]    sum;
    logic                 is_inf;
    logic                 overflow;
  } res_t;

endpackage

// File: rtl/mac_job_scheduler_if.sv
// mac_job_scheduler_if
//   Bundles every non-clock signal of the scheduler.
//   job_*  : job descriptor handshake (length-1, tag)
//   op_*   : operand pair handshake
//   flush  : single-cycle abort
//   mac_*  : issue side to the MAC and its return path
//   res_*  : result stream (no backpressure)
//   busy / err_timeout : status
//   slave  = scheduler side, master = AFU/MAC side.
interface mac_job_scheduler_if
  import mac_job_scheduler_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  logic              job_valid;
  logic              job_ready;
  logic [LEN_W-1:0]  job_len;
  logic [TAG_W-1:0]  job_tag;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic [DATA_W-1:0] mac_unum1;
  logic [DATA_W-1:0] mac_unum2;
  logic              mac_valid;
  logic              mac_finish;
  logic              mac_rst;
  logic [DATA_W-1:0] mac_sum;
  logic              mac_isInf;
  logic              mac_overflow;
  logic              mac_finish_out;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_sum;
  logic              res_isInf;
  logic              res_overflow;
  logic              busy;
  logic              err_timeout;

  modport slave (
    input  job_valid, job_len, job_tag, op_valid, op_a, op_b, flush,
           mac_sum, mac_isInf, mac_overflow, mac_finish_out,
    output job_ready, op_ready, mac_unum1, mac_unum2, mac_valid, mac_finish,
           mac_rst, res_valid, res_tag, res_sum, res_isInf, res_overflow,
           busy, err_timeout
  );

  modport master (
    output job_valid, job_len, job_tag, op_valid, op_a, op_b, flush,
           mac_sum, mac_isInf, mac_overflow, mac_finish_out,
    input  job_ready, op_ready, mac_unum1, mac_unum2, mac_valid, mac_finish,
           mac_rst, res_valid, res_tag, res_sum, res_isInf, res_overflow,
           busy, err_timeout
  );
endinterface

// File: rtl/mac_job_scheduler_tag_fifo.sv
// mac_job_scheduler_tag_fifo
//   Two-entry tag FIFO tracking jobs issued to the MAC in issue order.
//   clk, rst_n      : clock, async active-low reset
//   clr             : synchronous clear (pointers and count)
//   push, push_data : enqueue a tag
//   pop, pop_data   : dequeue; pop_data is the current head
//   empty, full     : occupancy flags
//   A push while full is accepted only when a pop frees the slot in the same cycle.
module mac_job_scheduler_tag_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign empty    = (cnt_q == 2'd0);
  assign full     = (cnt_q == 2'd2);
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage is qualified by cnt_q, so it needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler
//   Streams dot-product jobs onto one multiply_accumulator, keeping at most
//   MAX_OUT jobs in flight, and returns each finished sum with its tag.
//   clk, rst_n : clock, async active-low reset
//   bus        : job/op handshakes, flush, MAC issue/return, result, status
module mac_job_scheduler
  import mac_job_scheduler_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  mac_job_scheduler_if.slave  bus
);
  localparam int              OUT_W  = $clog2(MAX_OUT + 1);
  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;

  logic              job_ready_w, op_ready_w;
  logic              job_xfer, op_xfer, last_beat, pop_ok;
  logic [TAG_W-1:0]  fifo_head;
  logic              fifo_empty, fifo_full;
  res_t              res_w;

  logic [DATA_W-1:0] a_p1, b_p1;
  logic              vld_p1, fin_p1, mac_rst_p1;
  res_t              res_p1;
  logic              res_vld_p1;

  assign op_ready_w = (state_q == STREAM) && !bus.flush;
  assign op_xfer    = bus.op_valid && op_ready_w;
  assign last_beat  = op_xfer && (len_cnt_q == '0);
  assign job_xfer   = bus.job_valid && job_ready_w;
  // a return with nothing outstanding is dropped; a flush discards any return
  assign pop_ok     = bus.mac_finish_out && !fifo_empty && !bus.flush;

  // In STREAM a new job is only taken on the last beat, so the next job's
  // first operand can follow with no bubble.
  always_comb begin
    job_ready_w = 1'b0;
    if (!bus.flush) begin
      if (state_q == IDLE) job_ready_w = (int'(out_q) < MAX_OUT);
      else                 job_ready_w = last_beat && ((int'(out_q) + 1) < MAX_OUT);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    cur_tag_d = cur_tag_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_xfer) begin
            state_d   = STREAM;
            len_cnt_d = bus.job_len;
            cur_tag_d = bus.job_tag;
          end
        end
        STREAM: begin
          if (op_xfer) len_cnt_d = len_cnt_q - LEN_W'(1);
          if (last_beat) begin
            if (job_xfer) begin
              len_cnt_d = bus.job_len;
              cur_tag_d = bus.job_tag;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // outstanding count and watchdog
  always_comb begin
    out_d  = out_q;
    wdog_d = wdog_q;
    err_d  = err_q;
    if (bus.flush) begin
      out_d  = '0;
      wdog_d = '0;
      err_d  = 1'b0;
    end else begin
      case ({last_beat, pop_ok})
        2'b10:   out_d = out_q + OUT_W'(1);
        2'b01:   out_d = out_q - OUT_W'(1);
        default: out_d = out_q;
      endcase
      if (pop_ok || (last_beat && out_q == '0)) wdog_d = '0;
      else if (out_q != '0 && wdog_q != WD_MAX) wdog_d = wdog_q + WD_W'(1);
      err_d = err_q || (wdog_d == WD_MAX);
    end
  end

  always_comb begin
    res_w          = res_p1;
    res_w.tag      = TAG_W_DEF'(fifo_head);
    res_w.sum      = bus.mac_sum;
    res_w.is_inf   = bus.mac_isInf;
    res_w.overflow = bus.mac_overflow;
  end

  mac_job_scheduler_tag_fifo #(.W(TAG_W)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.flush),
    .push      (last_beat),
    .push_data (cur_tag_q),
    .pop       (pop_ok),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_cnt_q <= '0;
      cur_tag_q <= '0;
      out_q     <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      cur_tag_q <= cur_tag_d;
      out_q     <= out_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
    end
  end

  // ---- stage p1: MAC issue and result return registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1       <= '0;
      b_p1       <= '0;
      vld_p1     <= 1'b0;
      fin_p1     <= 1'b0;
      mac_rst_p1 <= 1'b0;
      res_p1     <= '0;
      res_vld_p1 <= 1'b0;
    end else begin
      vld_p1     <= op_xfer;
      fin_p1     <= last_beat;
      mac_rst_p1 <= bus.flush;
      res_vld_p1 <= pop_ok;
      if (op_xfer) begin
        a_p1 <= bus.op_a;
        b_p1 <= bus.op_b;
      end
      if (pop_ok) res_p1 <= res_w;
    end
  end

  assign bus.job_ready    = job_ready_w;
  assign bus.op_ready     = op_ready_w;
  assign bus.mac_unum1    = a_p1;
  assign bus.mac_unum2    = b_p1;
  assign bus.mac_valid    = vld_p1;
  assign bus.mac_finish   = fin_p1;
  assign bus.mac_rst      = mac_rst_p1;
  assign bus.res_valid    = res_vld_p1;
  assign bus.res_tag      = TAG_W'(res_p1.tag);
  assign bus.res_sum      = res_p1.sum;
  assign bus.res_isInf    = res_p1.is_inf;
  assign bus.res_overflow = res_p1.overflow;
  assign bus.busy         = (state_q != IDLE) || (out_q != '0);
  assign bus.err_timeout  = err_q;

  logic unused_ok;
  assign unused_ok = fifo_full;
endmodule

// File: tb/tb_mac_job_scheduler.sv
module tb_mac_job_scheduler;
  localparam int LEN_W = 16;
  localparam int TAG_W = 8;
  localparam int TO    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_job_scheduler_if #(.LEN_W(LEN_W), .TAG_W(TAG_W)) bus();

  mac_job_scheduler #(
    .LEN_W(LEN_W), .TAG_W(TAG_W), .MAX_OUT(2), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] a, input logic fin);
    check_eq({tag, ".vld"}, 64'(bus.mac_valid), 64'd1);
    check_eq({tag, ".a"},   64'(bus.mac_unum1), 64'(a));
    check_eq({tag, ".b"},   64'(bus.mac_unum2), 64'(a + 32'd1));
    check_eq({tag, ".fin"}, 64'(bus.mac_finish), 64'(fin));
  endtask

  // drive one operand at the current negedge, check its issue one cycle later
  task automatic send_op(input string tag, input logic [31:0] a, input logic fin);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = a + 32'd1;
    @(negedge clk);
    chk_issue(tag, a, fin);
  endtask

  task automatic job(input logic [15:0] len, input logic [7:0] tag);
    bus.job_valid = 1'b1;
    bus.job_len   = len;
    bus.job_tag   = tag;
  endtask

  // MAC signals finish_out now; the result must be on res_* next cycle
  task automatic mac_ret(input string tag, input logic [31:0] sum, input logic [7:0] etag);
    bus.mac_finish_out = 1'b1;
    bus.mac_sum        = sum;
    @(negedge clk);
    bus.mac_finish_out = 1'b0;
    check_eq({tag, ".rvld"}, 64'(bus.res_valid), 64'd1);
    check_eq({tag, ".rtag"}, 64'(bus.res_tag), 64'(etag));
    check_eq({tag, ".rsum"}, 64'(bus.res_sum), 64'(sum));
  endtask

  initial begin
    bus.job_valid = 0; bus.job_len = '0; bus.job_tag = '0;
    bus.op_valid = 0; bus.op_a = '0; bus.op_b = '0; bus.flush = 0;
    bus.mac_sum = '0; bus.mac_isInf = 0; bus.mac_overflow = 0; bus.mac_finish_out = 0;

    // reset
    repeat (3) @(negedge clk);
    check_eq("rst.mac_valid", 64'(bus.mac_valid), 64'd0);
    check_eq("rst.mac_rst",   64'(bus.mac_rst), 64'd0);
    check_eq("rst.res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("rst.busy",      64'(bus.busy), 64'd0);
    check_eq("rst.err",       64'(bus.err_timeout), 64'd0);
    check_eq("rst.op_ready",  64'(bus.op_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle.job_ready", 64'(bus.job_ready), 64'd1);

    // single job, 4 elements, tag A1
    job(16'd3, 8'hA1);
    #1 check_eq("s.job_ready", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    bus.job_valid = 0;
    send_op("s.b0", 32'd1, 1'b0);
    send_op("s.b1", 32'd2, 1'b0);
    send_op("s.b2", 32'd3, 1'b0);
    send_op("s.b3", 32'd4, 1'b1);
    bus.op_valid = 0;
    check_eq("s.busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check_eq("s.idle_vld", 64'(bus.mac_valid), 64'd0);
    check_eq("s.idle_fin", 64'(bus.mac_finish), 64'd0);
    repeat (18) @(negedge clk);
    check_eq("s.noret", 64'(bus.res_valid), 64'd0);
    mac_ret("s", 32'h1234, 8'hA1);
    @(negedge clk);
    check_eq("s.rvld_off", 64'(bus.res_valid), 64'd0);
    check_eq("s.busy_off", 64'(bus.busy), 64'd0);

    // ping-pong limit: tags 5,6,7 len=0
    job(16'd0, 8'd5);
    #1 check_eq("pp.rdy5", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    job(16'd0, 8'd6);
    bus.op_valid = 1; bus.op_a = 32'h50; bus.op_b = 32'h51;
    #1 check_eq("pp.rdy6", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    chk_issue("pp.i5", 32'h50, 1'b1);
    job(16'd0, 8'd7);
    bus.op_a = 32'h60; bus.op_b = 32'h61;
    #1 check_eq("pp.rdy7a", 64'(bus.job_ready), 64'd0);
    @(negedge clk);
    chk_issue("pp.i6", 32'h60, 1'b1);
    bus.op_valid = 0;
    #1 check_eq("pp.rdy7b", 64'(bus.job_ready), 64'd0);
    @(negedge clk);
    check_eq("pp.rdy7c", 64'(bus.job_ready), 64'd0);
    check_eq("pp.bubble", 64'(bus.mac_valid), 64'd0);
    mac_ret("pp.r5", 32'h55, 8'd5);
    #1 check_eq("pp.rdy7d", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    bus.job_valid = 0;
    send_op("pp.i7", 32'h70, 1'b1);
    bus.op_valid = 0;
    mac_ret("pp.r6", 32'h66, 8'd6);
    mac_ret("pp.r7", 32'h77, 8'd7);
    // spurious return with nothing outstanding
    bus.mac_finish_out = 1;
    @(negedge clk);
    bus.mac_finish_out = 0;
    check_eq("pp.spur_prev", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    check_eq("spur.rvld", 64'(bus.res_valid), 64'd0);
    check_eq("spur.busy", 64'(bus.busy), 64'd0);

    // bubbles: len=1, op_valid 1,0,1,0
    job(16'd1, 8'h33);
    @(negedge clk);
    bus.job_valid = 0;
    send_op("bub.b0", 32'h10, 1'b0);
    bus.op_valid = 0;
    @(negedge clk);
    check_eq("bub.v1", 64'(bus.mac_valid), 64'd0);
    check_eq("bub.f1", 64'(bus.mac_finish), 64'd0);
    send_op("bub.b1", 32'h20, 1'b1);
    bus.op_valid = 0;
    @(negedge clk);
    check_eq("bub.v3", 64'(bus.mac_valid), 64'd0);
    check_eq("bub.f3", 64'(bus.mac_finish), 64'd0);
    mac_ret("bub", 32'h3333, 8'h33);

    // simultaneous push (last beat of B) and pop (return of A)
    @(negedge clk);
    job(16'd0, 8'h0A);
    @(negedge clk);
    job(16'd1, 8'h0B);
    bus.op_valid = 1; bus.op_a = 32'hA0; bus.op_b = 32'hA1;
    @(negedge clk);
    bus.job_valid = 0;
    chk_issue("pp2.iA", 32'hA0, 1'b1);
    send_op("pp2.iB0", 32'hB0, 1'b0);
    bus.op_a = 32'hB1; bus.op_b = 32'hB2;
    mac_ret("pp2.rA", 32'hAAAA, 8'h0A);
    bus.op_valid = 0;
    chk_issue("pp2.iB1", 32'hB1, 1'b1);
    #1;
    check_eq("pp2.busy", 64'(bus.busy), 64'd1);
    check_eq("pp2.out1", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    mac_ret("pp2.rB", 32'hBBBB, 8'h0B);
    @(negedge clk);
    check_eq("pp2.busy_off", 64'(bus.busy), 64'd0);

    // flush after 2 of 8 elements
    job(16'd7, 8'h0F);
    @(negedge clk);
    bus.job_valid = 0;
    send_op("fl.b0", 32'h100, 1'b0);
    send_op("fl.b1", 32'h101, 1'b0);
    bus.op_a = 32'h102; bus.op_b = 32'h103;
    bus.flush = 1;
    job(16'd0, 8'hEE);
    #1;
    check_eq("fl.op_ready", 64'(bus.op_ready), 64'd0);
    check_eq("fl.job_ready", 64'(bus.job_ready), 64'd0);
    @(negedge clk);
    bus.flush = 0; bus.op_valid = 0; bus.job_valid = 0;
    check_eq("fl.mac_rst", 64'(bus.mac_rst), 64'd1);
    check_eq("fl.mac_vld", 64'(bus.mac_valid), 64'd0);
    check_eq("fl.mac_fin", 64'(bus.mac_finish), 64'd0);
    check_eq("fl.busy", 64'(bus.busy), 64'd0);
    bus.mac_finish_out = 1;
    @(negedge clk);
    bus.mac_finish_out = 0;
    check_eq("fl.rst_off", 64'(bus.mac_rst), 64'd0);
    @(negedge clk);
    check_eq("fl.no_res", 64'(bus.res_valid), 64'd0);
    job(16'd0, 8'h42);
    @(negedge clk);
    bus.job_valid = 0;
    send_op("fl.new", 32'h200, 1'b1);
    bus.op_valid = 0;
    mac_ret("fl.r", 32'h4242, 8'h42);
    @(negedge clk);

    // watchdog: job never returns
    job(16'd0, 8'h99);
    @(negedge clk);
    bus.job_valid = 0;
    send_op("to.i", 32'h300, 1'b1);
    bus.op_valid = 0;
    repeat (TO - 1) @(negedge clk);
    check_eq("to.before", 64'(bus.err_timeout), 64'd0);
    @(negedge clk);
    check_eq("to.set", 64'(bus.err_timeout), 64'd1);
    repeat (10) @(negedge clk);
    check_eq("to.sticky", 64'(bus.err_timeout), 64'd1);
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    check_eq("to.clr", 64'(bus.err_timeout), 64'd0);
    check_eq("to.mac_rst", 64'(bus.mac_rst), 64'd1);
    check_eq("to.busy", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
